// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs inhibit, request-to-send, bit shift and ACK over open-drain enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_clk_oe,
  output logic       o_dat_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] ILAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] IPRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_prev_q;
  logic       fe, timed, tout;

  assign fe    = clk_prev_q & ~clk_sync_q[1];
  assign tout  = (tcnt_q == TMAX);
  assign timed = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                 (state_q == S_ACK) || (state_q == S_WAIT);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    icnt_d   = icnt_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          data_d   = i_data;
          par_d    = ~^i_data;
          icnt_d   = '0;
          tcnt_d   = '0;
          bcnt_d   = '0;
          err_d    = 2'd0;
          clk_oe_d = 1'b1;
          dat_oe_d = (INHIBIT_CYCLES == 1);
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        icnt_d = icnt_q + IW'(1);
        // start bit must be on the wire during the last inhibit cycle
        if (icnt_q == IPRE) dat_oe_d = 1'b1;
        if (icnt_q == ILAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (fe) begin
          dat_oe_d = ~data_q[0];
          bcnt_d   = 4'd1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fe) begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q < 4'd8) begin
            dat_oe_d = ~data_q[bcnt_q[2:0]];
          end else if (bcnt_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          bcnt_d  = bcnt_q + 4'd1;
          err_d   = dat_sync_q[1] ? 2'd1 : 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (clk_sync_q[1] && dat_sync_q[1]) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (timed) begin
      tcnt_d = fe ? '0 : tcnt_q + TW'(1);
      if (tout) begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        err_d    = 2'd2;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      par_q      <= 1'b0;
      icnt_q     <= '0;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'd0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_q      <= par_d;
      icnt_q     <= icnt_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_sync_q <= {clk_sync_q[0], i_ps2_clk};
      dat_sync_q <= {dat_sync_q[0], i_ps2_dat};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_clk_oe = clk_oe_q;
  assign o_dat_oe = dat_oe_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule
